// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed gfedcba display bus,
// waits for a stable one-hot digit enable, and reconstructs the hex nibble
// shown on each digit, flagging blank and illegal segment patterns.
module sevenseg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  update,
    output logic [DIGITS-1:0]     upd_digit
);

    // Counter values: capture fires at STABLE_CYCLES, then the counter parks
    // one above so a long stable period yields exactly one capture.
    localparam logic [CNT_W-1:0] CAPTURE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] SAT_CNT     = CNT_W'(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

    logic [DIGITS-1:0]   sampleDig_q;
    logic [6:0]          sampleSeg_q;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [4*DIGITS-1:0] hex_q,      hex_d;
    logic [DIGITS-1:0]   valid_q,    valid_d;
    logic [DIGITS-1:0]   err_q,      err_d;
    logic                update_q,   update_d;
    logic [DIGITS-1:0]   updDigit_q, updDigit_d;

    logic       inOneHot;
    logic       sameAsSample;
    logic       capture;
    logic [4:0] decoded;
    logic       segBlank;
    logic [3:0] newNib;
    logic       newValid;
    logic       newErr;

    // True when exactly one digit enable bit is set.
    function automatic logic isOneHot(input logic [DIGITS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // Returns {legal, nibble}; legal=0 for anything outside the encoding table.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1101111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    // Stability counting and capture decision; a capture always decodes the
    // already-sampled pair, even if the pins change on the capture edge.
    always_comb begin
        inOneHot     = isOneHot(dig_en);
        sameAsSample = (dig_en == sampleDig_q) && (seg_in == sampleSeg_q);

        if (sameAsSample && inOneHot) begin
            cnt_d = (cnt_q == SAT_CNT) ? cnt_q : cnt_q + ONE_CNT;
        end else begin
            cnt_d = inOneHot ? ONE_CNT : '0;
        end

        capture  = (cnt_q == CAPTURE_CNT);
        decoded  = decodeSeg(sampleSeg_q);
        segBlank = (sampleSeg_q == 7'b0);

        hex_d      = hex_q;
        valid_d    = valid_q;
        err_d      = err_q;
        update_d   = 1'b0;
        updDigit_d = '0;
        newNib     = 4'h0;
        newValid   = 1'b0;
        newErr     = 1'b0;

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sampleDig_q[i]) begin
                    newNib   = decoded[4] ? decoded[3:0] : hex_q[4*i +: 4];
                    newValid = decoded[4];
                    newErr   = !decoded[4] && !segBlank;
                    if ({newNib, newValid, newErr} !=
                        {hex_q[4*i +: 4], valid_q[i], err_q[i]}) begin
                        hex_d[4*i +: 4] = newNib;
                        valid_d[i]      = newValid;
                        err_d[i]        = newErr;
                        update_d        = 1'b1;
                        updDigit_d[i]   = 1'b1;
                    end
                end
            end
        end
    end

    // Sample register, counter and all registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sampleDig_q <= '0;
            sampleSeg_q <= '0;
            cnt_q       <= '0;
            hex_q       <= '0;
            valid_q     <= '0;
            err_q       <= '0;
            update_q    <= 1'b0;
            updDigit_q  <= '0;
        end else begin
            sampleDig_q <= dig_en;
            sampleSeg_q <= seg_in;
            cnt_q       <= cnt_d;
            hex_q       <= hex_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            update_q    <= update_d;
            updDigit_q  <= updDigit_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign update      = update_q;
    assign upd_digit   = updDigit_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Testbench for sevenseg_scan_decoder: directed scans checked every cycle
// against a window-history model, plus hand-computed literal expectations.
module tb_sevenseg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int S      = 8;

    logic                 clk_in = 1'b0;
    logic                 reset;
    logic [6:0]           seg_in;
    logic [DIGITS-1:0]    dig_en;
    logic [4*DIGITS-1:0]  hex_out;
    logic [DIGITS-1:0]    digit_valid;
    logic [DIGITS-1:0]    digit_err;
    logic                 update;
    logic [DIGITS-1:0]    upd_digit;

    int checks     = 0;
    int errors     = 0;
    int pulseCount = 0;
    int pulseBase  = 0;
    logic started  = 1'b0;

    // Model state
    logic [15:0] mHex    = '0;
    logic [3:0]  mValid  = '0;
    logic [3:0]  mErr    = '0;
    logic        mUpdate = 1'b0;
    logic [3:0]  mUpd    = '0;
    logic [10:0] hist[$];

    logic [6:0] segTable [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    sevenseg_scan_decoder #(
        .DIGITS(DIGITS), .STABLE_CYCLES(S), .CNT_W(8)
    ) dut (
        .clk_in(clk_in), .reset(reset), .seg_in(seg_in), .dig_en(dig_en),
        .hex_out(hex_out), .digit_valid(digit_valid), .digit_err(digit_err),
        .update(update), .upd_digit(upd_digit)
    );

    // 10-time-unit clock
    always #5 clk_in = ~clk_in;

    function automatic logic [4:0] modelDecode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (segTable[k] == s) return {1'b1, 4'(k)};
        end
        return 5'b0;
    endfunction

    // One clock of the model: capture when the last S sampled pairs are one
    // identical one-hot pair and the pair before that window was different.
    task automatic modelStep();
        logic [10:0] w0;
        logic [4:0]  dec;
        logic [3:0]  nNib;
        logic        nValid, nErr;
        int          n;
        bit          cap;
        mUpdate = 1'b0;
        mUpd    = '0;
        n       = hist.size();
        cap     = 0;
        w0      = '0;
        if (n >= S) begin
            w0  = hist[n-S];
            cap = ($countones(w0[10:7]) == 1);
            for (int k = n - S; k < n; k++) if (hist[k] != w0) cap = 0;
            if (n > S && hist[n-S-1] == w0) cap = 0;
        end
        if (cap) begin
            dec = modelDecode(w0[6:0]);
            for (int i = 0; i < DIGITS; i++) begin
                if (w0[7+i]) begin
                    nNib   = dec[4] ? dec[3:0] : mHex[4*i +: 4];
                    nValid = dec[4];
                    nErr   = !dec[4] && (w0[6:0] != 7'b0);
                    if (nNib != mHex[4*i +: 4] || nValid != mValid[i] || nErr != mErr[i]) begin
                        mHex[4*i +: 4] = nNib;
                        mValid[i]      = nValid;
                        mErr[i]        = nErr;
                        mUpdate        = 1'b1;
                        mUpd[i]        = 1'b1;
                    end
                end
            end
        end
        hist.push_back({dig_en, seg_in});
        if (hist.size() > S + 1) void'(hist.pop_front());
    endtask

    // Model advances on the same events as the DUT registers.
    initial forever begin
        @(posedge clk_in or posedge reset);
        if (reset) begin
            mHex = '0; mValid = '0; mErr = '0; mUpdate = 1'b0; mUpd = '0;
            hist.delete();
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (started) begin
            checkOutput("hex_out",     32'(hex_out),     32'(mHex));
            checkOutput("digit_valid", 32'(digit_valid), 32'(mValid));
            checkOutput("digit_err",   32'(digit_err),   32'(mErr));
            checkOutput("update",      32'(update),      32'(mUpdate));
            checkOutput("upd_digit",   32'(upd_digit),   32'(mUpd));
            if (update) pulseCount++;
        end
    end

    // Hold a digit/segment pair for n rising edges; called just after a negedge.
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_en = d;
        seg_in = s;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic runScan();
        logic [6:0] pats [4];
        pats[0] = 7'b1110001;  // F
        pats[1] = 7'b1001111;  // 3
        pats[2] = 7'b1110111;  // A
        pats[3] = 7'b0000110;  // 1
        for (int i = 0; i < DIGITS; i++) begin
            applyStimulus(4'(1 << i), pats[i], 20);
            applyStimulus(4'b0000, 7'b0, 2);
        end
    endtask

    initial begin
        reset  = 1'b1;
        dig_en = '0;
        seg_in = '0;
        repeat (2) @(negedge clk_in);
        checkOutput("reset_hex",    32'(hex_out),     32'h0);
        checkOutput("reset_valid",  32'(digit_valid), 32'h0);
        checkOutput("reset_update", 32'(update),      32'h0);
        reset   = 1'b0;
        started = 1'b1;

        // Single digit: "2" on digit 0, captured on the ninth edge
        applyStimulus(4'b0001, 7'b1011011, 8);
        checkOutput("single_pre_valid", 32'(digit_valid), 32'h0);
        applyStimulus(4'b0000, 7'b0, 1);
        checkOutput("single_hex",    32'(hex_out),     32'h0002);
        checkOutput("single_valid",  32'(digit_valid), 32'h1);
        checkOutput("single_update", 32'(update),      32'h1);
        checkOutput("single_upd",    32'(upd_digit),   32'h1);
        applyStimulus(4'b0000, 7'b0, 1);
        checkOutput("single_update_drop", 32'(update), 32'h0);

        // Full scan, then an identical rescan
        pulseBase = pulseCount;
        runScan();
        checkOutput("scan_hex",    32'(hex_out),     32'h1A3F);
        checkOutput("scan_valid",  32'(digit_valid), 32'hF);
        checkOutput("scan_pulses", 32'(pulseCount - pulseBase), 32'd4);
        pulseBase = pulseCount;
        runScan();
        checkOutput("rescan_pulses", 32'(pulseCount - pulseBase), 32'd0);

        // Glitch: one edge short of a capture
        pulseBase = pulseCount;
        applyStimulus(4'b0010, 7'b1111111, 7);
        applyStimulus(4'b0000, 7'b0, 3);
        checkOutput("glitch_hex",    32'(hex_out), 32'h1A3F);
        checkOutput("glitch_pulses", 32'(pulseCount - pulseBase), 32'd0);

        // Multi-hot and all-zero enables never capture
        applyStimulus(4'b0011, 7'b0000110, 50);
        applyStimulus(4'b0000, 7'b0000110, 50);
        applyStimulus(4'b0000, 7'b0, 2);
        checkOutput("illegal_hex",    32'(hex_out),     32'h1A3F);
        checkOutput("illegal_valid",  32'(digit_valid), 32'hF);
        checkOutput("illegal_pulses", 32'(pulseCount - pulseBase), 32'd0);

        // Illegal pattern on digit 2, then blank
        pulseBase = pulseCount;
        applyStimulus(4'b0100, 7'b1000000, 8);
        applyStimulus(4'b0000, 7'b0, 2);
        checkOutput("err_err",    32'(digit_err),   32'h4);
        checkOutput("err_valid",  32'(digit_valid), 32'hB);
        checkOutput("err_nibble", 32'(hex_out[11:8]), 32'hA);
        checkOutput("err_pulses", 32'(pulseCount - pulseBase), 32'd1);
        pulseBase = pulseCount;
        applyStimulus(4'b0100, 7'b0000000, 8);
        applyStimulus(4'b0000, 7'b0, 2);
        checkOutput("blank_err",    32'(digit_err),   32'h0);
        checkOutput("blank_valid",  32'(digit_valid), 32'hB);
        checkOutput("blank_hex",    32'(hex_out),     32'h1A3F);
        checkOutput("blank_pulses", 32'(pulseCount - pulseBase), 32'd1);

        // Asynchronous reset after five stable edges
        applyStimulus(4'b0001, 7'b0111111, 5);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_hex",   32'(hex_out),     32'h0);
        checkOutput("midreset_valid", 32'(digit_valid), 32'h0);
        checkOutput("midreset_err",   32'(digit_err),   32'h0);
        @(negedge clk_in);
        reset = 1'b0;
        applyStimulus(4'b0001, 7'b0111111, 8);
        checkOutput("post_reset_wait", 32'(digit_valid), 32'h0);
        applyStimulus(4'b0000, 7'b0, 1);
        checkOutput("post_reset_valid",  32'(digit_valid), 32'h1);
        checkOutput("post_reset_hex",    32'(hex_out),     32'h0);
        checkOutput("post_reset_update", 32'(update),      32'h1);
        applyStimulus(4'b0000, 7'b0, 2);

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
